ir_trace_latch: RTL and testbench

- Sits directly upstream of the 4x4 grid box renderer. Produces the 16-bit traced-box mask that drives its ir_in port.
- Takes 16 raw IR beam sensors, one per grid box, index = row*4 + col.
- Synchronises and debounces each sensor, then sticky-latches every box the wand has passed over.
- Tracks trace order and count, and ends a trace on an idle timeout or when all 16 boxes are latched.

---
 rtl/ir_trace_latch.sv | 152 +++++++++++++++
 tb/tb_ir_trace_latch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_trace_latch.sv
// ir_trace_latch: synchronises and debounces 16 IR grid sensors, then
// sticky-latches traced boxes and tracks trace order, count and completion.
module ir_trace_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 8,
  parameter int unsigned DB_W            = 20,
  parameter int unsigned TO_W            = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_raw,
  input  logic        clear,
  output logic [15:0] ir_out,
  output logic        new_box,
  output logic [3:0]  last_box,
  output logic [4:0]  trace_count,
  output logic        trace_done,
  output logic        timed_out
);

  localparam int unsigned N_BOX = 16;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACING = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  logic [N_BOX-1:0] r_sync1;
  logic [N_BOX-1:0] r_sync2;
  logic [N_BOX-1:0] r_db;
  logic [N_BOX-1:0] r_db_q;
  logic [N_BOX-1:0] r_rise;
  logic [DB_W-1:0]  r_db_cnt [N_BOX];

  state_t           r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic [N_BOX-1:0] r_ir_out;
  logic             r_new_box;
  logic [IDX_W-1:0] r_last_box;
  logic [CNT_W-1:0] r_trace_count;
  logic             r_trace_done;
  logic             r_timed_out;

  logic [N_BOX-1:0] w_fresh;
  logic [CNT_W-1:0] w_pop;
  logic [IDX_W-1:0] w_hi_idx;
  logic [CNT_W-1:0] w_count_next;

  // Input synchroniser, per-bit debounce and registered rising-edge detect.
  // Untouched by clear so a held sensor must release before it can re-latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      r_rise  <= '0;
      for (int i = 0; i < int'(N_BOX); i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= ir_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      r_rise  <= r_db & ~r_db_q;
      for (int i = 0; i < int'(N_BOX); i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Newly traced boxes this cycle: their count and the highest index among them.
  assign w_fresh = r_rise & ~r_ir_out;

  always_comb begin
    w_pop    = '0;
    w_hi_idx = '0;
    for (int i = 0; i < int'(N_BOX); i++) begin
      if (w_fresh[i]) begin
        w_pop    = w_pop + CNT_W'(1);
        w_hi_idx = IDX_W'(i);
      end
    end
    w_count_next = r_trace_count + w_pop;
  end

  // Trace FSM with sticky mask, order/count tracking and idle timeout.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_ir_out      <= '0;
      r_new_box     <= 1'b0;
      r_last_box    <= '0;
      r_trace_count <= '0;
      r_trace_done  <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      r_new_box <= 1'b0;
      case (r_state)
        S_IDLE, S_TRACING: begin
          if (w_fresh != '0) begin
            r_ir_out      <= r_ir_out | w_fresh;
            r_trace_count <= w_count_next;
            r_last_box    <= w_hi_idx;
            r_new_box     <= 1'b1;
            r_to_cnt      <= '0;
            if (w_count_next == CNT_W'(N_BOX)) begin
              r_state      <= S_DONE;
              r_trace_done <= 1'b1;
              r_timed_out  <= 1'b0;
            end else begin
              r_state <= S_TRACING;
            end
          end else if (r_state == S_TRACING) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              r_state      <= S_DONE;
              r_trace_done <= 1'b1;
              r_timed_out  <= 1'b1;
            end else if (r_to_cnt != {TO_W{1'b1}}) begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ir_out      = r_ir_out;
  assign new_box     = r_new_box;
  assign last_box    = r_last_box;
  assign trace_count = r_trace_count;
  assign trace_done  = r_trace_done;
  assign timed_out   = r_timed_out;

endmodule

// File: tb/tb_ir_trace_latch.sv
// Testbench for ir_trace_latch: directed test-plan scenarios plus randomized
// sensor activity, all checked against a run-length behavioural model.
module tb_ir_trace_latch;

  localparam int DEB = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_raw;
  logic        clear;
  logic [15:0] ir_out;
  logic        new_box;
  logic [3:0]  last_box;
  logic [4:0]  trace_count;
  logic        trace_done;
  logic        timed_out;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  ir_trace_latch #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .DB_W           (20),
    .TO_W           (28)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_raw     (ir_raw),
    .clear      (clear),
    .ir_out     (ir_out),
    .new_box    (new_box),
    .last_box   (last_box),
    .trace_count(trace_count),
    .trace_done (trace_done),
    .timed_out  (timed_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Sensor path: two-cycle synchroniser delay, then a sensor's debounced level
  // follows its synced level once that level has been held DEB samples.
  // A debounced rise reaches the mask two cycles later.
  localparam int M_IDLE = 0, M_TRACE = 1, M_DONE = 2;
  logic [15:0] m_rd1 = '0, m_rd2 = '0, m_db = '0, m_sprev = '0;
  logic [15:0] m_rise_a = '0, m_rise_b = '0, m_ir = '0;
  int          m_run [16];
  logic [4:0]  m_cnt = '0;
  logic [3:0]  m_last = '0;
  logic        m_nb = 1'b0, m_done = 1'b0, m_tof = 1'b0;
  int          m_to = 0, m_st = M_IDLE;
  logic [15:0] mv_s, mv_fresh, mv_rose;

  always @(posedge clk) begin
    if (reset) begin
      m_rd1 = '0; m_rd2 = '0; m_db = '0; m_sprev = '0;
      m_rise_a = '0; m_rise_b = '0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
      m_ir = '0; m_cnt = '0; m_last = '0; m_nb = 1'b0;
      m_done = 1'b0; m_tof = 1'b0; m_to = 0; m_st = M_IDLE;
    end else begin
      mv_s  = m_rd2;
      m_rd2 = m_rd1;
      m_rd1 = ir_raw;
      mv_fresh = m_rise_b & ~m_ir;
      mv_rose  = '0;
      for (int i = 0; i < 16; i++) begin
        if (mv_s[i] == m_sprev[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 1;
        m_sprev[i] = mv_s[i];
        if (mv_s[i] != m_db[i] && m_run[i] >= DEB) begin
          m_db[i] = mv_s[i];
          if (mv_s[i]) mv_rose[i] = 1'b1;
        end
      end
      m_rise_b = m_rise_a;
      m_rise_a = mv_rose;
      if (clear) begin
        m_ir = '0; m_cnt = '0; m_last = '0; m_nb = 1'b0;
        m_done = 1'b0; m_tof = 1'b0; m_to = 0; m_st = M_IDLE;
      end else begin
        m_nb = 1'b0;
        if (m_st != M_DONE && mv_fresh != '0) begin
          m_ir  = m_ir | mv_fresh;
          m_cnt = m_cnt + 5'($countones(mv_fresh));
          for (int i = 0; i < 16; i++) if (mv_fresh[i]) m_last = 4'(i);
          m_nb = 1'b1;
          m_to = 0;
          if (m_cnt == 5'd16) begin
            m_st = M_DONE; m_done = 1'b1; m_tof = 1'b0;
          end else begin
            m_st = M_TRACE;
          end
        end else if (m_st == M_TRACE) begin
          if (m_to >= TMO - 1) begin
            m_st = M_DONE; m_done = 1'b1; m_tof = 1'b1;
          end else begin
            m_to = m_to + 1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk_eq("m_ir_out",      32'(ir_out),      32'(m_ir));
    chk_eq("m_new_box",     32'(new_box),     32'(m_nb));
    chk_eq("m_last_box",    32'(last_box),    32'(m_last));
    chk_eq("m_trace_count", 32'(trace_count), 32'(m_cnt));
    chk_eq("m_trace_done",  32'(trace_done),  32'(m_done));
    chk_eq("m_timed_out",   32'(timed_out),   32'(m_tof));
  endtask

  // Advance one clock, then sample outputs on the falling edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (new_box) pulses++;
      cmp_model();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
    pulses = 0;
  endtask

  logic [15:0] tog;

  initial begin
    reset  = 1'b1;
    clear  = 1'b0;
    ir_raw = '0;

    // Reset state
    do_reset(3);
    chk_eq("rst_ir_out", 32'(ir_out), 32'h0);
    chk_eq("rst_new_box", 32'(new_box), 32'h0);
    chk_eq("rst_count", 32'(trace_count), 32'h0);
    chk_eq("rst_done", 32'(trace_done), 32'h0);

    // Single box 5
    ir_raw = 16'h0020;
    cyc(10);
    ir_raw = '0;
    chk_eq("b5_ir_out", 32'(ir_out), 32'h0020);
    chk_eq("b5_pulses", 32'(pulses), 32'd1);
    chk_eq("b5_last", 32'(last_box), 32'd5);
    chk_eq("b5_count", 32'(trace_count), 32'd1);
    chk_eq("b5_tracing", 32'(trace_done), 32'd0);

    // Glitch shorter than the debounce window
    do_reset(2);
    ir_raw = 16'h0008;
    cyc(2);
    ir_raw = '0;
    cyc(10);
    chk_eq("glitch_ir_out", 32'(ir_out), 32'h0);
    chk_eq("glitch_pulses", 32'(pulses), 32'd0);

    // Boxes 0,1,2 in order, retrigger box 1, then idle timeout
    do_reset(2);
    ir_raw = 16'h0001; cyc(5);
    ir_raw = 16'h0002; cyc(5);
    ir_raw = 16'h0004; cyc(5);
    ir_raw = 16'h0002; cyc(5);
    ir_raw = 16'h0000; cyc(12);
    chk_eq("seq_ir_out", 32'(ir_out), 32'h0007);
    chk_eq("seq_count", 32'(trace_count), 32'd3);
    chk_eq("seq_last", 32'(last_box), 32'd2);
    chk_eq("seq_pulses", 32'(pulses), 32'd3);
    chk_eq("seq_done", 32'(trace_done), 32'd1);
    chk_eq("seq_timed_out", 32'(timed_out), 32'd1);
    ir_raw = 16'h0200; cyc(10);
    ir_raw = '0;
    chk_eq("done_ignore_ir", 32'(ir_out), 32'h0007);
    chk_eq("done_ignore_pulses", 32'(pulses), 32'd3);

    // Boxes 4 and 12 together
    do_reset(2);
    ir_raw = 16'h1010; cyc(10);
    ir_raw = '0;
    chk_eq("pair_ir_out", 32'(ir_out), 32'h1010);
    chk_eq("pair_count", 32'(trace_count), 32'd2);
    chk_eq("pair_last", 32'(last_box), 32'd12);
    chk_eq("pair_pulses", 32'(pulses), 32'd1);

    // Full grid within timeout
    do_reset(2);
    for (int g = 0; g < 4; g++) begin
      ir_raw = ir_raw | (16'h000F << (4 * g));
      cyc(5);
    end
    cyc(12);
    chk_eq("full_ir_out", 32'(ir_out), 32'hFFFF);
    chk_eq("full_count", 32'(trace_count), 32'd16);
    chk_eq("full_last", 32'(last_box), 32'd15);
    chk_eq("full_done", 32'(trace_done), 32'd1);
    chk_eq("full_timed_out", 32'(timed_out), 32'd0);
    chk_eq("full_pulses", 32'(pulses), 32'd4);

    // Clear in DONE with box 7 held
    ir_raw = 16'h0080;
    clear  = 1'b1;
    cyc(1);
    clear  = 1'b0;
    chk_eq("clr_ir_out", 32'(ir_out), 32'h0);
    chk_eq("clr_count", 32'(trace_count), 32'd0);
    chk_eq("clr_last", 32'(last_box), 32'd0);
    chk_eq("clr_done", 32'(trace_done), 32'd0);
    chk_eq("clr_timed_out", 32'(timed_out), 32'd0);
    pulses = 0;
    cyc(12);
    chk_eq("held7_no_latch", 32'(ir_out), 32'h0);
    ir_raw = 16'h0000; cyc(10);
    ir_raw = 16'h0080; cyc(10);
    chk_eq("rebreak7_ir_out", 32'(ir_out), 32'h0080);
    chk_eq("rebreak7_last", 32'(last_box), 32'd7);
    chk_eq("rebreak7_pulses", 32'(pulses), 32'd1);

    // Mid-trace reset
    do_reset(1);
    chk_eq("midrst_ir_out", 32'(ir_out), 32'h0);
    chk_eq("midrst_count", 32'(trace_count), 32'd0);
    chk_eq("midrst_last", 32'(last_box), 32'd0);
    ir_raw = '0;

    // Randomized activity: slow toggles, then a glitch-heavy phase
    for (int c = 0; c < 4000; c++) begin
      tog = '0;
      for (int b = 0; b < 16; b++) begin
        if (c < 2500) begin
          if ($urandom_range(0, 29) == 0) tog[b] = 1'b1;
        end else begin
          if ($urandom_range(0, 3) == 0) tog[b] = 1'b1;
        end
      end
      ir_raw = ir_raw ^ tog;
      clear  = ($urandom_range(0, 149) == 0);
      reset  = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    clear = 1'b0;
    reset = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
